sm1068_uart_cmd_rx: RTL

- UART receiver and command-frame decoder; the inbound counterpart of the bot's existing UART transmitter (8N1, 115200 baud, 50 MHz).
- Deserialises bytes from the host/simulator line, then parses the fixed ASCII frame '#', cmd, digit, digit, LF into a command code plus an arena node index.
- The bot controller uses the decoded command to override the path-planner start/end nodes.

---
 rtl/sm1068_uart_cmd_rx.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/sm1068_uart_cmd_rx.sv
// rtl/sm1068_uart_cmd_rx.sv - 8N1 UART receiver with '#'-cmd-digit-digit-LF command frame decoder
module sm1068_uart_cmd_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_CLKS = 5000000,
    parameter int MAX_NODE     = 36
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       cmd_valid,
    output logic [7:0] cmd_code,
    output logic [5:0] cmd_node,
    output logic       cmd_err,
    output logic       busy
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CLKS);
    localparam logic [6:0] MAX_N = 7'(MAX_NODE);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;
    typedef enum logic [2:0] {P_IDLE, P_CMD, P_D1, P_D0, P_TERM} p_state_t;

    rx_state_t        rx_state, rx_next;
    p_state_t         p_state, p_next;
    logic             rx_meta, rx_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic [7:0]       cmd_lat;
    logic [3:0]       d1, d0;
    logic [TO_W-1:0]  gap_cnt;
    logic [6:0]       node_sum;
    logic             err_nxt, valid_nxt, is_cmd, is_digit;

    // Flops preset high so a reset never looks like a start bit
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            IDLE:      if (!rx_s) rx_next = START;
            START:     if (cnt == HALF) rx_next = rx_s ? IDLE : DATA;
            DATA:      if (cnt == LAST && bit_idx == 3'd7) rx_next = STOP;
            STOP:      if (cnt == LAST) rx_next = rx_s ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rx_s) rx_next = IDLE;
            default:   rx_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            rx_state   <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_state   <= rx_next;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            // Counter restarts on every state change and on every bit boundary
            if (rx_state == IDLE || rx_state == WAIT_HIGH || rx_next != rx_state || cnt == LAST)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (rx_state == START)
                bit_idx <= '0;
            if (rx_state == DATA && cnt == LAST) begin
                shift   <= {rx_s, shift[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            if (rx_state == STOP && cnt == LAST) begin
                if (rx_s) begin
                    byte_data  <= shift;
                    byte_valid <= 1'b1;
                end else begin
                    frame_err  <= 1'b1;
                end
            end
        end
    end

    assign is_cmd   = byte_data inside {8'd78, 8'd87, 8'd80, 8'd70};
    assign is_digit = (byte_data >= 8'h30) && (byte_data <= 8'h39);
    assign node_sum = 7'(d1) * 7'd10 + 7'(d0);

    always_comb begin
        p_next    = p_state;
        err_nxt   = 1'b0;
        valid_nxt = 1'b0;
        if (byte_valid) begin
            if (byte_data == 8'h23) begin
                // '#' always starts a new frame; abandoning one in progress is an error
                p_next  = P_CMD;
                err_nxt = (p_state != P_IDLE);
            end else begin
                case (p_state)
                    P_CMD: begin
                        p_next  = is_cmd ? P_D1 : P_IDLE;
                        err_nxt = !is_cmd;
                    end
                    P_D1: begin
                        p_next  = is_digit ? P_D0 : P_IDLE;
                        err_nxt = !is_digit;
                    end
                    P_D0: begin
                        p_next  = is_digit ? P_TERM : P_IDLE;
                        err_nxt = !is_digit;
                    end
                    P_TERM: begin
                        p_next = P_IDLE;
                        if (byte_data == 8'h0A && node_sum <= MAX_N) valid_nxt = 1'b1;
                        else                                         err_nxt   = 1'b1;
                    end
                    default: p_next = P_IDLE;
                endcase
            end
        end else if (p_state != P_IDLE && (frame_err || gap_cnt == TO_MAX)) begin
            p_next  = P_IDLE;
            err_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            p_state   <= P_IDLE;
            cmd_valid <= 1'b0;
            cmd_err   <= 1'b0;
            cmd_code  <= '0;
            cmd_node  <= '0;
            cmd_lat   <= '0;
            d1        <= '0;
            d0        <= '0;
            gap_cnt   <= '0;
        end else begin
            p_state   <= p_next;
            cmd_valid <= valid_nxt;
            cmd_err   <= err_nxt;
            if (byte_valid && p_state == P_CMD) cmd_lat <= byte_data;
            if (byte_valid && p_state == P_D1)  d1 <= byte_data[3:0];
            if (byte_valid && p_state == P_D0)  d0 <= byte_data[3:0];
            if (valid_nxt) begin
                cmd_code <= cmd_lat;
                cmd_node <= node_sum[5:0];
            end
            if (p_state == P_IDLE || byte_valid) gap_cnt <= '0;
            else if (gap_cnt != TO_MAX)          gap_cnt <= gap_cnt + 1'b1;
        end
    end

    assign busy = (rx_state != IDLE) || (p_state != P_IDLE);
endmodule
